// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared definitions for the USB receive drain path.
//   PID codes, drain FSM state encoding and CRC16 constants.
package usb_rx_pkg;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [15:0] CRC16_SEED     = 16'hFFFF;
   localparam logic [15:0] CRC16_POLY     = 16'hA001;
   localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

   function automatic logic is_data_pid(input logic [3:0] pid);
      return (pid == PID_DATA0) || (pid == PID_DATA1);
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: byte-wide combinational CRC16 step (LSB-first, reflected poly 0xA001).
//   crc_in  - current register value
//   data_in - byte consumed, bit 0 first
//   crc_out - register value after the byte
module usb_crc16
   import usb_rx_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 8; i++)
         crc_out = (crc_out[0] ^ data_in[i]) ? ((crc_out >> 1) ^ CRC16_POLY) : (crc_out >> 1);
   end

endmodule

// File: rtl/usb_rx_packet_drain.sv
// usb_rx_packet_drain: drains usb_receiver's RX FIFO, tracks packet boundaries,
// strips/checks the DATA0/DATA1 CRC16 and reports one status pulse per packet.
//   clk, n_rst            - clock, asynchronous active-low reset
//   rx_data/rx_empty      - receiver FIFO head (first-word-fall-through) and empty flag
//   rx_rcving/rx_error    - receiver in-packet and error flags
//   rx_pid                - receiver decoded PID, sampled at end of packet
//   rx_r_enable           - one-cycle FIFO pop
//   out_data/out_valid    - forwarded payload byte stream, out_ready accepts
//   pkt_done              - one-cycle end-of-packet pulse
//   pkt_pid/len/crc_ok/err - held packet status, updated with pkt_done
// Build option: define USB_RX_CRC16_EN to implement the CRC16 check; otherwise
// pkt_crc_ok is always 1 (the trailing two data-packet bytes are still stripped).
module usb_rx_packet_drain
   import usb_rx_pkg::*;
#(
   parameter int LEN_W = 11
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_empty,
   input  logic             rx_rcving,
   input  logic             rx_error,
   input  logic [3:0]       rx_pid,
   output logic             rx_r_enable,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             pkt_done,
   output logic [3:0]       pkt_pid,
   output logic [LEN_W-1:0] pkt_len,
   output logic             pkt_crc_ok,
   output logic             pkt_err
);

   localparam logic [LEN_W-1:0] LEN_MAX = '1;

   state_e           state_q, state_d;
   logic             pop_q, pop_d;
   logic [7:0]       hb0_q, hb0_d, hb1_q, hb1_d;
   logic [1:0]       hb_cnt_q, hb_cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             err_q, err_d;
   logic [3:0]       pid_q, pid_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [3:0]       pkt_pid_q, pkt_pid_d;
   logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
   logic             pkt_crc_ok_q, pkt_crc_ok_d;
   logic             pkt_err_q, pkt_err_d;
   logic             out_free, eop, shift, crc_ok;

   // The holdback line keeps the last two popped bytes back so the CRC of a
   // data packet never reaches the output; shift moves its oldest byte out.
   always_comb begin
      out_free = !out_valid_q || out_ready;
      eop      = (state_q == ST_ACTIVE) && !rx_rcving && rx_empty;
      pop_d    = (state_q == ST_ACTIVE) && !rx_empty && !pop_q && (hb_cnt_q != 2'd2 || out_free);
      shift    = (pop_d && hb_cnt_q == 2'd2) || (state_q == ST_FLUSH && hb_cnt_q != 2'd0 && out_free);
   end

`ifdef USB_RX_CRC16_EN
   logic [15:0] crc_q, crc_d, crc_next;

   usb_crc16 u_crc16 (
      .crc_in  (crc_q),
      .data_in (rx_data),
      .crc_out (crc_next)
   );

   // Seeding every IDLE cycle is equivalent to seeding on entry to ACTIVE.
   always_comb crc_d = (state_q == ST_IDLE) ? CRC16_SEED : pop_d ? crc_next : crc_q;

   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) crc_q <= CRC16_SEED;
      else        crc_q <= crc_d;

   // Only the data-packet path (leaving ACTIVE) reports a real CRC result.
   assign crc_ok = (state_q != ST_ACTIVE) || (hb_cnt_q == 2'd2 && crc_q == CRC16_RESIDUAL);
`else
   assign crc_ok = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      hb0_d        = hb0_q;
      hb1_d        = hb1_q;
      hb_cnt_d     = hb_cnt_q;
      pid_d        = pid_q;
      len_d        = (shift && len_q != LEN_MAX) ? len_q + 1'b1 : len_q;
      err_d        = err_q | (state_q == ST_ACTIVE && rx_error) | (shift && len_q >= LEN_MAX - 1'b1);
      out_data_d   = shift ? hb0_q : out_data_q;
      out_valid_d  = shift || (out_valid_q && !out_ready);
      pkt_pid_d    = pkt_pid_q;
      pkt_len_d    = pkt_len_q;
      pkt_crc_ok_d = pkt_crc_ok_q;
      pkt_err_d    = pkt_err_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_rcving || !rx_empty) begin
               state_d  = ST_ACTIVE;
               hb_cnt_d = 2'd0;
               len_d    = '0;
               err_d    = 1'b0;
            end
         end
         ST_ACTIVE: begin
            if (pop_d) begin
               hb0_d    = (hb_cnt_q == 2'd0) ? rx_data : (hb_cnt_q == 2'd2) ? hb1_q : hb0_q;
               hb1_d    = (hb_cnt_q == 2'd0) ? hb1_q : rx_data;
               hb_cnt_d = (hb_cnt_q == 2'd2) ? 2'd2 : hb_cnt_q + 2'd1;
            end
            if (eop) begin
               pid_d = rx_pid;
               if (is_data_pid(rx_pid)) begin
                  state_d  = ST_DONE;
                  hb_cnt_d = 2'd0;
                  err_d    = err_d | (hb_cnt_q != 2'd2);
               end else begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if (shift) begin
               hb0_d    = hb1_q;
               hb_cnt_d = hb_cnt_q - 2'd1;
            end
            if (hb_cnt_q == 2'd0 || (shift && hb_cnt_q == 2'd1)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Status is captured on the way into DONE so it is valid with pkt_done.
      if (state_d == ST_DONE && state_q != ST_DONE) begin
         pkt_pid_d    = pid_d;
         pkt_len_d    = len_d;
         pkt_crc_ok_d = crc_ok;
         pkt_err_d    = err_d;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= ST_IDLE;
         pop_q        <= 1'b0;
         hb0_q        <= 8'h00;
         hb1_q        <= 8'h00;
         hb_cnt_q     <= 2'd0;
         len_q        <= '0;
         err_q        <= 1'b0;
         pid_q        <= 4'h0;
         out_data_q   <= 8'h00;
         out_valid_q  <= 1'b0;
         pkt_pid_q    <= 4'h0;
         pkt_len_q    <= '0;
         pkt_crc_ok_q <= 1'b0;
         pkt_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pop_q        <= pop_d;
         hb0_q        <= hb0_d;
         hb1_q        <= hb1_d;
         hb_cnt_q     <= hb_cnt_d;
         len_q        <= len_d;
         err_q        <= err_d;
         pid_q        <= pid_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         pkt_pid_q    <= pkt_pid_d;
         pkt_len_q    <= pkt_len_d;
         pkt_crc_ok_q <= pkt_crc_ok_d;
         pkt_err_q    <= pkt_err_d;
      end
   end

   assign rx_r_enable = pop_d;
   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign pkt_done    = (state_q == ST_DONE);
   assign pkt_pid     = pkt_pid_q;
   assign pkt_len     = pkt_len_q;
   assign pkt_crc_ok  = pkt_crc_ok_q;
   assign pkt_err     = pkt_err_q;

endmodule

// File: tb/tb_usb_rx_packet_drain.sv
// tb_usb_rx_packet_drain: directed and randomized packets against a queue-based packet model.
module tb_usb_rx_packet_drain;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_empty = 1'b1;
   logic        rx_rcving = 1'b0;
   logic        rx_error = 1'b0;
   logic [3:0]  rx_pid = 4'h0;
   logic        rx_r_enable;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        pkt_done;
   logic [3:0]  pkt_pid;
   logic [10:0] pkt_len;
   logic        pkt_crc_ok;
   logic        pkt_err;

   int   checks = 0;
   int   errors = 0;
   int   pops = 0;
   int   done_seen = 0;
   int   stall_viol = 0;
   logic popped = 1'b0;
   logic stall_prev = 1'b0;
   logic [7:0] stall_data = 8'h00;
   bq_t  fifo;
   bq_t  got;

   always #5 clk = ~clk;

   usb_rx_packet_drain dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .rx_data     (rx_data),
      .rx_empty    (rx_empty),
      .rx_rcving   (rx_rcving),
      .rx_error    (rx_error),
      .rx_pid      (rx_pid),
      .rx_r_enable (rx_r_enable),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .pkt_done    (pkt_done),
      .pkt_pid     (pkt_pid),
      .pkt_len     (pkt_len),
      .pkt_crc_ok  (pkt_crc_ok),
      .pkt_err     (pkt_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // USB CRC16 of a payload, as the transmitter computes it before complementing.
   function automatic logic [15:0] crc16(input bq_t b);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (b[i])
         for (int k = 0; k < 8; k++)
            c = (c[0] ^ b[i][k]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      return c;
   endfunction

   function automatic bq_t with_crc(input bq_t pl);
      logic [15:0] c;
      bq_t r;
      c = ~crc16(pl);
      r = pl;
      r.push_back(c[7:0]);
      r.push_back(c[15:8]);
      return r;
   endfunction

   // One clock: drive the FIFO head at the falling edge, observe, then pop after the rising edge.
   task automatic cycle();
      @(negedge clk);
      rx_empty = (fifo.size() == 0);
      rx_data  = rx_empty ? 8'h00 : fifo[0];
      #1;
      popped = rx_r_enable;
      if (rx_r_enable) pops++;
      if (out_valid && out_ready) got.push_back(out_data);
      if (stall_prev && out_data !== stall_data) stall_viol++;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (pkt_done) done_seen++;
      @(posedge clk);
      #1;
      if (popped && fifo.size() > 0) void'(fifo.pop_front());
   endtask

   // mode 0: always ready, 1: random ready, 2: ready held low for 200 cycles after the packet.
   task automatic run_pkt(input string tag, input logic [3:0] pid, input bq_t bytes, input int err_at, input int mode);
      bq_t  exp;
      logic data, exp_crc, exp_err;
      int   n, idx, keep;
      n = bytes.size();
      idx = 0;
      data = (pid == 4'b0011) || (pid == 4'b1011);
      keep = data ? ((n >= 2) ? n - 2 : 0) : n;
      exp = {};
      for (int i = 0; i < keep; i++) exp.push_back(bytes[i]);
      exp_err = (err_at >= 0) || (data && n < 2);
      exp_crc = 1'b1;
`ifdef USB_RX_CRC16_EN
      if (data) begin
         if (n >= 2) exp_crc = ((crc16(exp) ^ 16'hFFFF) == {bytes[n-1], bytes[n-2]});
         else        exp_crc = 1'b0;
      end
`endif
      got = {};
      done_seen = 0;
      pops = 0;
      stall_viol = 0;
      rx_pid = pid;
      rx_rcving = 1'b1;
      for (int t = 0; t < 6 || idx < n; t++) begin
         if (idx < n && $urandom_range(0, 1) == 1) begin
            fifo.push_back(bytes[idx]);
            idx++;
         end
         rx_error = (t == err_at);
         out_ready = (mode == 2) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         cycle();
      end
      rx_error = 1'b0;
      rx_rcving = 1'b0;
      if (mode == 2) begin
         for (int t = 0; t < 200; t++) begin
            out_ready = 1'b0;
            cycle();
         end
         check({tag, "/stall_valid"}, 32'(out_valid), 32'd1);
         check({tag, "/stall_data"}, 32'(out_data), 32'(bytes[0]));
         check({tag, "/stall_pops"}, pops, 3);
         check({tag, "/stall_nodone"}, done_seen, 0);
      end
      for (int t = 0; t < 400 && !(done_seen > 0 && !out_valid); t++) begin
         out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         cycle();
      end
      check({tag, "/done_once"}, done_seen, 1);
      check({tag, "/pid"}, 32'(pkt_pid), 32'(pid));
      check({tag, "/len"}, 32'(pkt_len), exp.size());
      check({tag, "/crc_ok"}, 32'(pkt_crc_ok), 32'(exp_crc));
      check({tag, "/err"}, 32'(pkt_err), 32'(exp_err));
      check({tag, "/count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("%s/byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
      check({tag, "/stable"}, stall_viol, 0);
   endtask

   initial begin
      logic [3:0] pids [7] = '{4'b0001, 4'b1001, 4'b0011, 4'b1011, 4'b0010, 4'b1010, 4'b1110};
      bq_t        pl, bytes;
      logic [3:0] pid;
      int         err_at;

      // Reset state
      n_rst = 1'b0;
      repeat (3) cycle();
      check("rst/r_enable", 32'(rx_r_enable), 0);
      check("rst/out_valid", 32'(out_valid), 0);
      check("rst/out_data", 32'(out_data), 0);
      check("rst/pkt_done", 32'(pkt_done), 0);
      check("rst/pkt_pid", 32'(pkt_pid), 0);
      check("rst/pkt_len", 32'(pkt_len), 0);
      check("rst/pkt_crc_ok", 32'(pkt_crc_ok), 0);
      check("rst/pkt_err", 32'(pkt_err), 0);
      n_rst = 1'b1;
      done_seen = 0;
      pops = 0;
      repeat (5) cycle();
      check("idle/no_done", done_seen, 0);
      check("idle/no_pop", pops, 0);

      // Directed packets
      run_pkt("data1_empty", 4'b1011, '{8'h00, 8'h00}, -1, 0);
      pl = '{8'h55, 8'hAA};
      run_pkt("data0_good", 4'b0011, with_crc(pl), -1, 0);
      bytes = with_crc(pl);
      bytes[bytes.size()-1] = bytes[bytes.size()-1] ^ 8'hFF;
      run_pkt("data0_badcrc", 4'b0011, bytes, -1, 0);
      run_pkt("ack_flush", 4'b0010, '{8'h12, 8'h34}, -1, 0);
      run_pkt("data0_short", 4'b0011, '{8'h7F}, -1, 0);
      run_pkt("out_rxerr", 4'b0001, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 3, 0);
      run_pkt("out_stall3", 4'b0001, '{8'h3C, 8'h5A, 8'h96}, -1, 2);
      run_pkt("out_stall6", 4'b0001, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, -1, 2);
      run_pkt("in_empty", 4'b1001, '{}, -1, 1);

      // Randomized packets
      for (int k = 0; k < 24; k++) begin
         pid = pids[$urandom_range(0, 6)];
         pl = {};
         for (int i = 0; i < int'($urandom_range(0, 6)); i++) pl.push_back(8'($urandom_range(0, 255)));
         bytes = pl;
         if ((pid == 4'b0011 || pid == 4'b1011) && $urandom_range(0, 3) != 0) begin
            bytes = with_crc(pl);
            if ($urandom_range(0, 3) == 0) bytes[bytes.size()-1] = bytes[bytes.size()-1] ^ 8'h01;
         end
         err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 5)) : -1;
         run_pkt($sformatf("rand%0d", k), pid, bytes, err_at, 1);
      end

      // Reset in the middle of a packet
      fifo = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      rx_pid = 4'b0001;
      rx_rcving = 1'b1;
      out_ready = 1'b0;
      repeat (12) cycle();
      n_rst = 1'b0;
      #1;
      check("rst_mid/out_valid", 32'(out_valid), 0);
      check("rst_mid/out_data", 32'(out_data), 0);
      check("rst_mid/r_enable", 32'(rx_r_enable), 0);
      fifo = {};
      rx_rcving = 1'b0;
      out_ready = 1'b1;
      stall_prev = 1'b0;
      done_seen = 0;
      repeat (3) cycle();
      n_rst = 1'b1;
      repeat (10) cycle();
      check("rst_mid/no_done", done_seen, 0);
      check("rst_mid/pkt_len", 32'(pkt_len), 0);
      check("rst_mid/idle_valid", 32'(out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
